vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, frame counter and
// registered sync / blanking / start-of-line / start-of-frame strobes.
// All strobes are decoded from the *next* position so they are registered
// alongside hpos/vpos and always describe the position presented with them.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int FCNT_W   = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  output logic [HW-1:0]     hpos,
  output logic [VW-1:0]     vpos,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

  // Cleared by reset; the first enabled cycle after reset presents (0,0)
  // with both start pulses instead of advancing, so the origin is never
  // skipped.
  logic primed;

  logic              h_wrap, v_wrap;
  logic [HW-1:0]     h_nxt;
  logic [VW-1:0]     v_nxt;
  logic [FCNT_W-1:0] f_nxt;
  logic              hs_nxt, vs_nxt, de_nxt;

  // Next raster position and the strobes that describe it.
  always_comb begin
    h_wrap = (hpos == HW'(H_TOTAL - 1));
    v_wrap = (vpos == VW'(V_TOTAL - 1));
    h_nxt  = h_wrap ? '0 : hpos + HW'(1);
    v_nxt  = vpos;
    f_nxt  = frame_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vpos + VW'(1);
      if (v_wrap) f_nxt = frame_cnt + FCNT_W'(1);
    end
    if (!primed) begin
      h_nxt = hpos;
      v_nxt = vpos;
      f_nxt = frame_cnt;
    end
    hs_nxt = (int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END);
    vs_nxt = (int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END);
    de_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
  end

  // Position, frame count and output strobes; everything holds while ena
  // is low except the start pulses, which drop so a stall cannot repeat them.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed      <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      frame_cnt   <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ena) begin
      primed      <= 1'b1;
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      frame_cnt   <= f_nxt;
      hsync       <= hs_nxt ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_nxt ? SYNC_POL : ~SYNC_POL;
      display_on  <= de_nxt;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a small 14x8 raster (H 8/2/3/1, V 4/1/2/1,
// active-low sync, 4-bit frame counter).
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [3:0] hpos;
  logic [2:0] vpos;
  logic       hsync, vsync, display_on, line_start, frame_start;
  logic [3:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .FCNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, v, hs, vs, de, ls, fs, f;
  } exp_t;

  typedef struct {
    logic r, e;
    exp_t x;
  } vec_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   fs_seen;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected outputs for a raster position, from the fixed 14x8 timing:
  // hsync low on columns 10..12, vsync low on lines 5..6, active 8x4.
  function automatic exp_t mk(input int h, input int v, input int f, input bit pulse);
    exp_t x;
    x.h  = h;
    x.v  = v;
    x.f  = f;
    x.hs = (h >= 10 && h <= 12) ? 0 : 1;
    x.vs = (v >= 5 && v <= 6) ? 0 : 1;
    x.de = (h < 8 && v < 4) ? 1 : 0;
    x.ls = (pulse && h == 0) ? 1 : 0;
    x.fs = (pulse && h == 0 && v == 0) ? 1 : 0;
    return x;
  endfunction

  // k enabled cycles after the priming cycle of a free-running raster.
  function automatic exp_t at_k(input int k);
    return mk(k % 14, (k / 14) % 8, (k / 112) % 16, 1'b1);
  endfunction

  task automatic step(input logic r, input logic e, input exp_t x);
    exp_t got;
    q.push_back(x);
    rst = r;
    ena = e;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_start === 1'b1) fs_seen++;
    got = q.pop_front();
    chk("hpos",        int'(hpos),        got.h);
    chk("vpos",        int'(vpos),        got.v);
    chk("hsync",       int'(hsync),       got.hs);
    chk("vsync",       int'(vsync),       got.vs);
    chk("display_on",  int'(display_on),  got.de);
    chk("line_start",  int'(line_start),  got.ls);
    chk("frame_start", int'(frame_start), got.fs);
    chk("frame_cnt",   int'(frame_cnt),   got.f);
  endtask

  vec_t tbl[11];
  exp_t rs;

  initial begin
    rs = mk(0, 0, 0, 1'b0);
    tbl[0]  = '{1'b1, 1'b1, rs};
    tbl[1]  = '{1'b1, 1'b0, rs};
    tbl[2]  = '{1'b0, 1'b0, rs};
    tbl[3]  = '{1'b0, 1'b1, '{0, 0, 1, 1, 1, 1, 1, 0}};
    tbl[4]  = '{1'b0, 1'b1, '{1, 0, 1, 1, 1, 0, 0, 0}};
    tbl[5]  = '{1'b0, 1'b0, '{1, 0, 1, 1, 1, 0, 0, 0}};
    tbl[6]  = '{1'b0, 1'b1, '{2, 0, 1, 1, 1, 0, 0, 0}};
    tbl[7]  = '{1'b0, 1'b1, '{3, 0, 1, 1, 1, 0, 0, 0}};
    tbl[8]  = '{1'b1, 1'b1, '{0, 0, 1, 1, 1, 0, 0, 0}};
    tbl[9]  = '{1'b0, 1'b1, '{0, 0, 1, 1, 1, 1, 1, 0}};
    tbl[10] = '{1'b0, 1'b1, '{1, 0, 1, 1, 1, 0, 0, 0}};

    #2;
    foreach (tbl[i]) step(tbl[i].r, tbl[i].e, tbl[i].x);

    // Free run for 16 frames and a bit: full raster, sync windows,
    // 112-cycle frame period, frame counter wrap 15 -> 0.
    step(1'b1, 1'b1, rs);
    fs_seen = 0;
    for (int k = 0; k <= 16 * 112 + 14; k++) step(1'b0, 1'b1, at_k(k));
    chk("frame_start_count_17_frames", fs_seen, 17);

    // Stall mid-hsync at column 11.
    step(1'b1, 1'b1, rs);
    for (int k = 0; k <= 11; k++) step(1'b0, 1'b1, at_k(k));
    for (int s = 0; s < 5; s++) step(1'b0, 1'b0, mk(11, 0, 0, 1'b0));
    step(1'b0, 1'b1, at_k(12));
    step(1'b0, 1'b1, at_k(13));
    step(1'b0, 1'b1, at_k(14));

    // Stall at the origin right after the priming pulse.
    step(1'b1, 1'b1, rs);
    fs_seen = 0;
    step(1'b0, 1'b1, at_k(0));
    for (int s = 0; s < 3; s++) step(1'b0, 1'b0, mk(0, 0, 0, 1'b0));
    for (int k = 1; k < 112; k++) step(1'b0, 1'b1, at_k(k));
    chk("frame_start_once_over_stall", fs_seen, 1);
    step(1'b0, 1'b1, at_k(112));

    // Reset in the middle of hsync and vsync (column 11, line 5).
    step(1'b1, 1'b1, rs);
    for (int k = 0; k <= 5 * 14 + 11; k++) step(1'b0, 1'b1, at_k(k));
    step(1'b1, 1'b1, rs);
    step(1'b0, 1'b1, at_k(0));
    step(1'b0, 1'b1, at_k(1));

    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
